cmd_rx: RTL and testbench

Byte-to-command assembler sitting between the UART receiver and the SUMP instruction decoder. Collects one opcode byte plus, for long commands, four argument bytes, then presents a complete `{opc, cmd}` word with a strobe. Includes a hold/ready handshake so a busy downstream can back-pressure it, and optional inter-byte timeout recovery.

---
 rtl/cmd_rx_pkg.sv | 21 ++
 rtl/cmd_rx.sv | 152 +++++++++++++++
 tb/tb_cmd_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_rx_pkg.sv
// Shared types and constants for the SUMP command receive path.
//
// Contents:
//   cmd_rx_state_t : command assembler FSM states
//   opc_t          : opcode byte type, shared by opcode consumers
//   CMD_LONG_BIT   : opcode bit that marks a long (argument-carrying) command
//   CMD_ARG_BYTES  : number of argument bytes following a long opcode
package cmd_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArgs,
    StIssue
  } cmd_rx_state_t;

  typedef logic [7:0] opc_t;

  localparam int unsigned CMD_LONG_BIT  = 7;
  localparam int unsigned CMD_ARG_BYTES = 4;

endpackage

// File: rtl/cmd_rx.sv
// Byte-to-command assembler between the UART receiver and the SUMP decoder.
// Collects an opcode byte and, for long commands (opcode bit 7 set), four
// argument bytes LSB first, then presents {opc_o, cmd_o} with a level strobe
// held until the downstream accepts it with rdy_i.
//
// Optional feature: define CMD_RX_TIMEOUT_EN to abort a partial long command
// after TIMEOUT_CYCLES idle cycles between argument bytes (pulses tmo_o).
//
// Ports:
//   clk_i    in   system clock, rising edge
//   rst_in   in   asynchronous active-low reset
//   rx_stb_i in   one-cycle strobe, rx_dat_i valid
//   rx_dat_i in   received byte
//   rdy_i    in   downstream accepts the presented command this cycle
//   stb_o    out  command valid, held until accepted
//   opc_o    out  opcode
//   cmd_o    out  argument word, zero for short commands
//   busy_o   out  partial long command in progress
//   ovf_o    out  one-cycle pulse when a byte is dropped
//   tmo_o    out  one-cycle pulse on timeout abort (0 without the macro)
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk_i,
  input  logic                         rst_in,
  input  logic                         rx_stb_i,
  input  logic [7:0]                   rx_dat_i,
  input  logic                         rdy_i,
  output logic                         stb_o,
  output opc_t                         opc_o,
  output logic [8*CMD_ARG_BYTES-1:0]   cmd_o,
  output logic                         busy_o,
  output logic                         ovf_o,
  output logic                         tmo_o
);

  localparam int unsigned CmdW = 8 * CMD_ARG_BYTES;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  cmd_rx_state_t     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  opc_t              opc_q, opc_d;
  logic [CmdW-1:0]   cmd_q, cmd_d;
  logic              ovf_q, ovf_d;
  logic              expire;

`ifdef CMD_RX_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            tmo_q, tmo_d;

  // Expiry is the step from 1 to 0; a byte on that same cycle wins.
  assign expire = (state_q == StArgs) && !rx_stb_i && (tmr_q == TmrW'(1));

  always_comb begin
    tmr_d = tmr_q;
    tmo_d = expire;
    if (rx_stb_i && (state_q != StIssue)) begin
      tmr_d = TmrW'(TIMEOUT_CYCLES);
    end else if ((state_q == StArgs) && (tmr_q != '0)) begin
      tmr_d = tmr_q - TmrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo_o = tmo_q;
`else
  assign expire = 1'b0;
  assign tmo_o  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    cmd_d   = cmd_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_stb_i) begin
          opc_d = rx_dat_i;
          if (!rx_dat_i[CMD_LONG_BIT]) begin
            cmd_d   = '0;
            state_d = StIssue;
          end else begin
            cnt_d   = '0;
            state_d = StArgs;
          end
        end
      end
      StArgs: begin
        if (rx_stb_i) begin
          cmd_d[8*cnt_q +: 8] = rx_dat_i;
          cnt_d               = cnt_q + 2'd1;
          if (cnt_q == 2'(CMD_ARG_BYTES - 1)) begin
            state_d = StIssue;
          end
        end else if (expire) begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (rdy_i) begin
          state_d = StIdle;
        end
        // Bytes arriving while a command is pending are dropped.
        if (rx_stb_i) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opc_q   <= '0;
      cmd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      cmd_q   <= cmd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stb_o  = (state_q == StIssue);
  assign busy_o = (state_q == StArgs);
  assign opc_o  = opc_q;
  assign cmd_o  = cmd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_cmd_rx.sv
// Scoreboard bench for cmd_rx: stimulus pushes expected {opc, cmd} words,
// a monitor pops and compares on every stb_o && rdy_i transfer.
module tb_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        rdy = 1'b1;
  logic        stb_o;
  logic [7:0]  opc_o;
  logic [31:0] cmd_o;
  logic        busy_o;
  logic        ovf_o;
  logic        tmo_o;

  cmd_rx #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i   (clk),
    .rst_in  (rst_n),
    .rx_stb_i(rx_stb),
    .rx_dat_i(rx_dat),
    .rdy_i   (rdy),
    .stb_o   (stb_o),
    .opc_o   (opc_o),
    .cmd_o   (cmd_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o),
    .tmo_o   (tmo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  opc;
    logic [31:0] cmd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   ovf_seen = 0;
  int   xfers = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] opc, input logic [31:0] cmd);
    exp_t e;
    e.opc = opc;
    e.cmd = cmd;
    sb.push_back(e);
  endtask

  // Drives one strobed byte; returns 1 time unit after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_stb = 1'b1;
    rx_dat = b;
    @(posedge clk);
    #1;
    rx_stb = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && stb_o && rdy) begin
      xfers++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer: got opc 0x%0h cmd 0x%0h, none expected", opc_o, cmd_o);
      end else begin
        mon_e = sb.pop_front();
        chk("xfer_opc", {24'h0, opc_o}, {24'h0, mon_e.opc});
        chk("xfer_cmd", cmd_o, mon_e.cmd);
      end
    end
    if (ovf_o) ovf_seen++;
  end

  initial begin
    int base_ovf;
    int base_xfer;
    logic [7:0] burst [5];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stb", {31'h0, stb_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_ovf", {31'h0, ovf_o}, 32'h0);
    chk("rst_tmo", {31'h0, tmo_o}, 32'h0);
    chk("rst_opc", {24'h0, opc_o}, 32'h0);
    chk("rst_cmd", cmd_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // Short command, 1-cycle latency and 1-cycle strobe with rdy high
    push(8'h02, 32'h0);
    send(8'h02);
    chk("short_latency", {31'h0, stb_o}, 32'h1);
    tick();
    chk("short_pulse_end", {31'h0, stb_o}, 32'h0);

    // Long command, LSB-first argument assembly
    push(8'hC0, 32'h44332211);
    send(8'hC0);
    chk("long_busy0", {31'h0, busy_o}, 32'h1);
    send(8'h11);
    chk("long_busy1", {31'h0, busy_o}, 32'h1);
    send(8'h22);
    chk("long_busy2", {31'h0, busy_o}, 32'h1);
    send(8'h33);
    chk("long_busy3", {31'h0, busy_o}, 32'h1);
    send(8'h44);
    chk("long_busy_done", {31'h0, busy_o}, 32'h0);
    chk("long_stb", {31'h0, stb_o}, 32'h1);
    tick();
    chk("long_pulse_end", {31'h0, stb_o}, 32'h0);

    // Back-pressure with a dropped byte
    rdy = 1'b0;
    push(8'h80, 32'hEFBEADDE);
    send(8'h80);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send(8'h01);
      else tick();
      chk("bp_stb", {31'h0, stb_o}, 32'h1);
      chk("bp_opc", {24'h0, opc_o}, 32'h80);
      chk("bp_cmd", cmd_o, 32'hEFBEADDE);
    end
    chk("bp_ovf_count", ovf_seen, 1);
    base_xfer = xfers;
    rdy = 1'b1;
    tick();
    chk("bp_released", {31'h0, stb_o}, 32'h0);
    chk("bp_one_xfer", xfers - base_xfer, 1);

    // Byte coinciding with the accepting cycle is still dropped
    rdy = 1'b0;
    push(8'h05, 32'h0);
    send(8'h05);
    rdy = 1'b1;
    rx_stb = 1'b1;
    rx_dat = 8'h07;
    tick();
    rx_stb = 1'b0;
    chk("coinc_idle", {31'h0, stb_o}, 32'h0);
    chk("coinc_ovf_pulse", {31'h0, ovf_o}, 32'h1);
    tick();
    chk("coinc_ovf_end", {31'h0, ovf_o}, 32'h0);
    chk("coinc_ovf_count", ovf_seen, 2);

    // Reset in the middle of a long command
    send(8'hC0);
    send(8'hAA);
    chk("mid_busy", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy_o}, 32'h0);
    chk("mid_rst_stb", {31'h0, stb_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    push(8'h11, 32'h0);
    send(8'h11);
    chk("post_rst_stb", {31'h0, stb_o}, 32'h1);
    tick();

    // Five SUMP reset bytes
    base_ovf  = ovf_seen;
    base_xfer = xfers;
    for (int i = 0; i < 5; i++) begin
      push(8'h00, 32'h0);
      send(8'h00);
    end
    tick();
    tick();
    chk("zeros_xfers", xfers - base_xfer, 5);
    chk("zeros_no_ovf", ovf_seen - base_ovf, 0);

    // Long command on consecutive-cycle strobes
    burst[0] = 8'hA5;
    burst[1] = 8'h01;
    burst[2] = 8'h02;
    burst[3] = 8'h03;
    burst[4] = 8'h04;
    push(8'hA5, 32'h04030201);
    @(posedge clk);
    #1;
    rx_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_dat = burst[i];
      tick();
    end
    rx_stb = 1'b0;
    chk("burst_stb", {31'h0, stb_o}, 32'h1);
    tick();

`ifdef CMD_RX_TIMEOUT_EN
    begin
      int k;
      send(8'hC0);
      send(8'h01);
      k = 0;
      while (!tmo_o && k < 30) begin
        tick();
        k++;
      end
      chk("tmo_delay", k, 8);
      chk("tmo_idle", {31'h0, busy_o}, 32'h0);
      tick();
      chk("tmo_pulse_end", {31'h0, tmo_o}, 32'h0);
      push(8'h00, 32'h0);
      send(8'h00);
      chk("tmo_next_short", {31'h0, stb_o}, 32'h1);
      tick();
    end
`else
    // Without the timeout a partial command waits indefinitely
    send(8'hC0);
    repeat (20) tick();
    chk("no_tmo_busy", {31'h0, busy_o}, 32'h1);
    chk("no_tmo_pulse", {31'h0, tmo_o}, 32'h0);
    push(8'hC0, 32'h0D0C0B0A);
    send(8'h0A);
    send(8'h0B);
    send(8'h0C);
    send(8'h0D);
    tick();
`endif

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
